// File: rtl/ram_s1p1c_ctrl_pkg.sv
// Shared types for the single-port RAM controller: port grant encoding and
// the smallest legal response-buffer depth.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_WRITE = 2'd1,
        GRANT_READ  = 2'd2
    } grant_e;

    localparam int RSP_DEPTH_MIN = 2;

endpackage

// File: rtl/ram_s1p1c_ctrl_rsp_fifo.sv
// Read-response FIFO: control state has an async reset, storage is left unreset.
// The head entry is visible combinationally.
module ram_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ram_s1p1c_ctrl.sv
// Arbitrates write and read request channels onto one single-port RAM and
// returns read data through a credit-limited response FIFO.
module ram_s1p1c_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    parameter  int RSP_DEPTH  = 3,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WORD_WIDTH-1:0] rsp_data_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    grant_e                grant;
    grant_e                last_grant_q;
    logic                  pending_q;
    logic                  rd_credit;
    logic [CNT_W:0]        inflight;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [WORD_WIDTH-1:0] head;

    // Credit counts both buffered and in-flight reads, from registers only,
    // so rsp_ready_i never reaches rd_ready_o combinationally.
    assign inflight  = {1'b0, count} + (CNT_W + 1)'(pending_q);
    assign rd_credit = (inflight < (CNT_W + 1)'(RSP_DEPTH));

    always_comb begin
        grant = GRANT_NONE;
        if (!rstn_i) begin
            grant = GRANT_NONE;
        end else if (wr_valid_i && rd_valid_i && rd_credit) begin
            grant = (last_grant_q == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
        end else if (wr_valid_i) begin
            grant = GRANT_WRITE;
        end else if (rd_valid_i && rd_credit) begin
            grant = GRANT_READ;
        end
    end

    assign wr_ready_o = (grant == GRANT_WRITE);
    assign rd_ready_o = (grant == GRANT_READ);

    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        case (grant)
            GRANT_WRITE: begin
                ram_we_o   = 1'b1;
                ram_addr_o = wr_addr_i;
                ram_data_o = wr_data_i;
            end
            GRANT_READ: ram_addr_o = rd_addr_i;
            default: ;
        endcase
    end

    // RAM address stage: a granted read returns data on the next edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q    <= 1'b0;
            last_grant_q <= GRANT_READ;
        end else begin
            pending_q <= (grant == GRANT_READ);
            if (grant != GRANT_NONE) last_grant_q <= grant;
        end
    end

    // RAM data stage: capture registered read data into the response FIFO.
    assign push = pending_q;
    assign pop  = rsp_valid_o && rsp_ready_i;

    ram_rsp_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (push),
        .push_data (ram_data_i),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign rsp_valid_o = !empty;
    assign rsp_data_o  = empty ? '0 : head;

    a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !$isunknown({wr_valid_i, rd_valid_i, rsp_ready_i}));

    a_wr_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (wr_valid_i && !wr_ready_o) |=>
            (!wr_valid_i || ($stable(wr_addr_i) && $stable(wr_data_i))));

    a_rd_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (rd_valid_i && !rd_ready_o) |=> (!rd_valid_i || $stable(rd_addr_i)));

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_data_o));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && full));

endmodule

// File: tb/tb_ram_s1p1c_ctrl.sv
// Directed bench for ram_s1p1c_ctrl with a behavioural single-port RAM and a
// queue-based response scoreboard.
module tb_ram_s1p1c_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] mem [0:255] = '{default: 8'h00};

    int            compared = 0;
    int            mismatched = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram_s1p1c_ctrl #(
        .WORD_WIDTH (DW),
        .WORD_COUNT (256),
        .RSP_DEPTH  (3)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_valid_i  (rd_valid),
        .rd_ready_o  (rd_ready),
        .rd_addr_i   (rd_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_wdata),
        .ram_data_i  (ram_rdata)
    );

    // Behavioural single-port RAM with one cycle of registered read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        if (!ok) check("wr_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        bit ok = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rd_ready) begin
                ok = 1'b1;
                exp_q.push_back(e);
            end
            tick();
        end
        rd_valid = 1'b0;
        if (!ok) check("rd_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int  acc;
        int  idx;
        bit  seen;
        bit  wrote;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_wdata, 0);
        rstn = 1'b1;
        tick();

        // Test 1: write then read, latency and single-cycle we
        rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 8'hA5;
        @(negedge clk);
        check("t1_wr_ready", wr_ready, 1);
        check("t1_ram_we", ram_we, 1);
        check("t1_ram_addr", ram_addr, 3);
        check("t1_ram_data", ram_wdata, 8'hA5);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        check("t1_we_pulse_end", ram_we, 0);
        tick();
        rd_valid = 1'b1; rd_addr = 8'd3;
        @(negedge clk);
        check("t1_rd_ready", rd_ready, 1);
        check("t1_rd_ram_we", ram_we, 0);
        check("t1_rd_ram_addr", ram_addr, 3);
        if (rd_ready) exp_q.push_back(8'hA5);
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp_valid_lat1", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_rsp_valid_lat2", rsp_valid, 1);
        tick();
        wait_drain();

        // Test 5: read-after-write to the same address
        do_read(8'd5, 8'h00);
        do_write(8'd5, 8'h3C);
        do_read(8'd5, 8'h3C);
        wait_drain();

        // Test 2: back-to-back reads of a preloaded region
        for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(8'h10 + i));
        fork
            begin
                rd_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    rd_addr = AW'(i);
                    @(negedge clk);
                    check("t2_rd_ready", rd_ready, 1);
                    if (rd_ready) exp_q.push_back(DW'(8'h10 + i));
                    tick();
                end
                rd_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                check("t2_first_rsp", seen, 1);
                repeat (7) begin
                    @(negedge clk);
                    check("t2_rsp_streak", rsp_valid, 1);
                end
            end
        join
        tick();
        wait_drain();

        // Test 3: consumer stalls, credit limits accepted reads
        rsp_ready = 1'b0;
        rd_valid = 1'b1;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            rd_addr = AW'(idx);
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(DW'(8'h10 + idx));
                idx++;
                acc++;
            end
            tick();
        end
        check("t3_accepted_while_stalled", acc, 3);
        wr_valid = 1'b1; wr_addr = 8'd20; wr_data = 8'h77;
        @(negedge clk);
        check("t3_wr_granted_in_stall", wr_ready, 1);
        check("t3_rd_blocked_in_stall", rd_ready, 0);
        tick();
        wr_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            rd_addr = AW'(idx);
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(DW'(8'h10 + idx));
                idx++;
            end
            tick();
        end
        rd_valid = 1'b0;
        check("t3_reads_resumed", idx, 5);
        wait_drain();

        // Test 4: round-robin after reset, write first
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'd40; wr_data = 8'hE0;
        rd_valid = 1'b1; rd_addr = 8'd1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t4_grant_pattern", {wr_ready, rd_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
            if (rd_ready) exp_q.push_back(8'h11);
            wrote = wr_ready;
            tick();
            if (wrote) begin
                wr_addr = wr_addr + 1'b1;
                wr_data = wr_data + 1'b1;
            end
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        wait_drain();

        // Test 6: reset with one read pending and two responses buffered
        rsp_ready = 1'b0;
        rd_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            rd_addr = AW'(idx);
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(DW'(8'h10 + idx));
                idx++;
            end
            tick();
        end
        rstn = 1'b0;
        #1;
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_rsp_data", rsp_data, 0);
        check("t6_rst_rd_ready", rd_ready, 0);
        check("t6_rst_wr_ready", wr_ready, 0);
        check("t6_rst_ram_we", ram_we, 0);
        check("t6_rst_ram_addr", ram_addr, 0);
        exp_q.delete();
        rd_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale_rsp", rsp_valid, 0);
            tick();
        end
        do_read(8'd2, 8'h12);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_s1p1c_ctrl.md
Name: ram_s1p1c_ctrl

Overview:
Initiator side of the single-port, single-clock RAM port (we/addr/data in, registered read data out, 1-cycle read latency).
- Takes independent valid/ready write-request and read-request channels and arbitrates them onto the single RAM port.
- Tracks the in-flight read and returns read data on a valid/ready response channel with credit-controlled buffering, so back-pressure never loses data.
- Sits between bus/stream logic and any ram_s1p1c-style array.

Parameters:
WORD_WIDTH, 8, data word width
WORD_COUNT, 256, RAM depth in words; ADDR_WIDTH = $clog2(WORD_COUNT) (localparam)
RSP_DEPTH, 3, read-response buffer entries; minimum 2; 3 gives one read per cycle with a continuously ready consumer

Ports:
clk_i  in  1  clock, all logic on rising edge
rstn_i  in  1  asynchronous active-low reset
wr_valid_i  in  1  write request valid
wr_ready_o  out  1  write request accepted
wr_addr_i  in  ADDR_WIDTH  write address
wr_data_i  in  WORD_WIDTH  write data
rd_valid_i  in  1  read request valid
rd_ready_o  out  1  read request accepted
rd_addr_i  in  ADDR_WIDTH  read address
rsp_valid_o  out  1  read data valid
rsp_ready_i  in  1  consumer accepts read data
rsp_data_o  out  WORD_WIDTH  read data
ram_we_o  out  1  to RAM we
ram_addr_o  out  ADDR_WIDTH  to RAM addr
ram_data_o  out  WORD_WIDTH  to RAM write data
ram_data_i  in  WORD_WIDTH  from RAM registered read data

Behaviour:
- Reset values: wr_ready_o=0, rd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0.
  - pending_q=0, buffer empty, last_grant_q=READ, so write wins the first tie.
- Credit rule: rd_credit = (count_q + pending_q < RSP_DEPTH).
  - Uses registered state only; there is no combinational path from rsp_ready_i to rd_ready_o.
- Grant, computed combinationally each cycle:
  - Write only valid: grant write.
  - Read only valid with rd_credit: grant read.
  - Both valid with rd_credit: round-robin, grant the channel not in last_grant_q.
  - Both valid without rd_credit: grant write.
  - Otherwise: no grant.
- wr_ready_o = grant==WRITE; rd_ready_o = grant==READ. A handshake means valid & ready on the same cycle.
- RAM drive, combinational from the grant:
  - Write grant: ram_we_o=1, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i.
  - Read grant: ram_we_o=0, ram_addr_o=rd_addr_i.
  - No grant: ram_we_o=0, ram_addr_o=0, ram_data_o=0.
  - ram_we_o is never X after reset.
- last_grant_q updates only on an actual grant.
- Read latency:
  - Read handshake at edge N sets pending_q=1.
  - At edge N+1, ram_data_i is pushed into the buffer and pending_q clears, unless another read was granted at N+1.
  - rsp_valid_o is high in the cycle after N+1, so best-case latency is 2 cycles from request to rsp_valid_o.
- Write cycles never push data; ram_data_i is ignored unless pending_q=1.
- Ordering: responses are in read-issue order.
  - A read granted after a write to the same address returns the new data, because the single port serialises them.
- Buffer: FIFO of RSP_DEPTH entries. rsp_valid_o = !empty; rsp_data_o = head.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty; count is unchanged.
  - Overflow is impossible by the credit rule; an assertion checks push && full never occurs.
- Reset mid-operation (async): pending read and buffered responses are discarded; no response is produced for them.
- Assertions (disabled in reset):
  - No X on wr_valid_i, rd_valid_i, rsp_ready_i.
  - A valid held without ready keeps its address and data stable.
  - rsp_valid_o with !rsp_ready_i holds rsp_data_o stable.

Decomposition:
- Package ram_ctrl_pkg: grant_e enum {GRANT_NONE, GRANT_WRITE, GRANT_READ} and a RSP_DEPTH_MIN=2 constant.
- One sub-module, ram_rsp_fifo: synchronous FIFO with WIDTH and DEPTH parameters.
  - Outputs count, full and empty; head is available combinationally.
  - Async active-low reset.

Test Plan:
1. Write 0xA5 to addr 3, then read addr 3 with rsp_ready_i=1 -> ram_we_o=1 for exactly 1 cycle with addr 3; rsp_valid_o rises 2 cycles after the read handshake with rsp_data_o=0xA5.
2. Back-to-back reads of addrs 0..7 (preloaded 0x10..0x17) with rsp_ready_i=1 -> rd_ready_o stays high every cycle; 8 responses 0x10..0x17 in order on 8 consecutive cycles.
3. Reads with rsp_ready_i=0 -> exactly 3 reads accepted, then rd_ready_o=0; writes still granted while reads stall. Raising rsp_ready_i drains 3 responses in order, then reads resume.
4. wr_valid_i and rd_valid_i held high together for 6 cycles -> grants alternate W,R,W,R,W,R starting with write after reset; no cycle grants both.
5. Read addr 5 immediately after write 0x3C to addr 5 (old value 0x00) -> response is 0x3C.
6. Assert rstn_i=0 while one read is pending and 2 responses are buffered -> all outputs reset immediately; after release no stale rsp_valid_o, and a fresh read returns correct data.
